tta_pcu: RTL and testbench

- Parametrised successor to the TTA program-counter controller. It stalls, branches and increments the PC.
- Adds the following:
  - N independent pipeline-stall sources.
  - A hardware return-address stack (call/return).
  - Optional PC-relative branch targets.
  - An explicit HALT state driven by enable_i.
- Sits between the TTA instruction decoder/move bus and the instruction cache/fetch port. Optimised for latency: stall_no and fetch_o are decoded directly from the state register.

---
 rtl/tta_pkg.sv | 14 +
 rtl/tta_ras.sv | 58 +++++
 rtl/tta_pcu.sv | 104 ++++++++++
 tb/tb_tta_pcu.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tta_pkg.sv
// Shared types and constants for the TTA program-counter unit.
package tta_pkg;

  typedef enum logic [1:0] {
    PCST_FETCH = 2'b00,
    PCST_MISS  = 2'b01,
    PCST_STALL = 2'b10,
    PCST_HALT  = 2'b11
  } pcst_e;

  localparam int unsigned REL_ABSOLUTE = 0;
  localparam int unsigned REL_PCREL    = 1;

endpackage

// File: rtl/tta_ras.sv
// Circular return-address stack: a full push drops the oldest entry and an
// empty pop leaves the pointers alone; both raise the sticky error flag.
module tta_ras #(
  parameter int unsigned WIDTH  = 18,
  parameter int unsigned RDEPTH = 4,
  parameter int unsigned RDBITS = 2
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             push,
  input  logic             pop,
  input  logic             conflict,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             err
);

  localparam int unsigned CW = RDBITS + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(RDEPTH);

  logic [WIDTH-1:0]  mem [RDEPTH];
  logic [RDBITS-1:0] ptr;
  logic [CW-1:0]     count;

  // ptr is the next free slot; once wrapped it also names the oldest entry
  assign top   = mem[ptr - RDBITS'(1)];
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      ptr   <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      if (push) begin
        ptr <= ptr + RDBITS'(1);
        if (full) err <= 1'b1;
        else      count <= count + CW'(1);
      end else if (pop) begin
        if (empty) begin
          err <= 1'b1;
        end else begin
          ptr   <= ptr - RDBITS'(1);
          count <= count - CW'(1);
        end
      end
      if (conflict) err <= 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (push) mem[ptr] <= push_data;
  end

endmodule

// File: rtl/tta_pcu.sv
// TTA program-counter unit: fetch/miss/stall/halt sequencing, PC next-value
// selection and call/return through the return-address stack.
import tta_pkg::*;

module tta_pcu #(
  parameter int unsigned      WIDTH    = 18,
  parameter logic [WIDTH-1:0] INIT     = '0,
  parameter int unsigned      NSTALL   = 2,
  parameter int unsigned      RDEPTH   = 4,
  parameter int unsigned      RDBITS   = 2,
  parameter int unsigned      RELATIVE = 0
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              enable_i,
  output logic [WIDTH-1:0]  pc_o,
  output logic              fetch_o,
  output logic              latch_o,
  input  logic              ack_i,
  input  logic              hit_i,
  input  logic [WIDTH-1:0]  target_i,
  input  logic              branch_i,
  input  logic              call_i,
  input  logic              ret_i,
  input  logic [NSTALL-1:0] op_i,
  input  logic [NSTALL-1:0] busy_i,
  output logic              stall_no,
  output logic              ras_empty_o,
  output logic              ras_full_o,
  output logic              ras_err_o
);

  pcst_e            state;
  logic             any_stall;
  logic             upd;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] ras_top;

  assign any_stall = |(op_i & busy_i);
  assign upd       = ack_i && ((state == PCST_FETCH) || (state == PCST_MISS));
  assign pc_inc    = pc_o + WIDTH'(1);
  assign tgt       = (RELATIVE == REL_PCREL) ? (pc_o + target_i) : target_i;

  // Decoded straight from the state register to keep them off the input paths
  assign stall_no = (state == PCST_FETCH);
  assign fetch_o  = (state == PCST_FETCH) || (state == PCST_MISS);
  assign latch_o  = ack_i;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state <= PCST_FETCH;
    end else begin
      case (state)
        PCST_FETCH: begin
          if (!enable_i)      state <= PCST_HALT;
          else if (!ack_i)    state <= PCST_MISS;
          else if (any_stall) state <= PCST_STALL;
        end
        // enable_i is not looked at so an outstanding refill always completes
        PCST_MISS: begin
          if (!any_stall && hit_i) state <= PCST_FETCH;
        end
        PCST_STALL: begin
          if (!any_stall) state <= enable_i ? PCST_FETCH : PCST_HALT;
        end
        PCST_HALT: begin
          if (enable_i) state <= PCST_FETCH;
        end
        default: state <= PCST_FETCH;
      endcase
    end
  end

  // Return wins over call; a return on an empty stack falls through to pc+1
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pc_o <= INIT;
    end else if (upd) begin
      if (ret_i)         pc_o <= ras_empty_o ? pc_inc : ras_top;
      else if (call_i)   pc_o <= tgt;
      else if (branch_i) pc_o <= tgt;
      else               pc_o <= pc_inc;
    end
  end

  tta_ras #(
    .WIDTH  (WIDTH),
    .RDEPTH (RDEPTH),
    .RDBITS (RDBITS)
  ) u_ras (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .push      (upd && call_i && !ret_i),
    .pop       (upd && ret_i),
    .conflict  (upd && call_i && ret_i),
    .push_data (pc_inc),
    .top       (ras_top),
    .empty     (ras_empty_o),
    .full      (ras_full_o),
    .err       (ras_err_o)
  );

endmodule

// File: tb/tb_tta_pcu.sv
// Bench for tta_pcu: absolute and PC-relative instances share stimulus and are
// checked every cycle against a queue-based reference model.
module tb_tta_pcu;

  localparam int unsigned W  = 12;
  localparam int unsigned NS = 2;
  localparam int unsigned RD = 4;
  localparam int unsigned RB = 2;
  localparam logic [W-1:0] INITV = 12'h100;

  localparam int ST_FETCH = 0;
  localparam int ST_MISS  = 1;
  localparam int ST_STALL = 2;
  localparam int ST_HALT  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, enable, ack, hit, branch, call, ret;
  logic [NS-1:0] op, busy;
  logic [W-1:0]  tgt [2];

  logic [W-1:0] pc [2];
  logic         fetch [2], latch [2], stall_n [2], empty [2], full [2], err [2];

  tta_pcu #(.WIDTH(W), .INIT(INITV), .NSTALL(NS), .RDEPTH(RD), .RDBITS(RB), .RELATIVE(0)) u_abs (
    .clock_i(clk), .reset_i(reset), .enable_i(enable), .pc_o(pc[0]), .fetch_o(fetch[0]),
    .latch_o(latch[0]), .ack_i(ack), .hit_i(hit), .target_i(tgt[0]), .branch_i(branch),
    .call_i(call), .ret_i(ret), .op_i(op), .busy_i(busy), .stall_no(stall_n[0]),
    .ras_empty_o(empty[0]), .ras_full_o(full[0]), .ras_err_o(err[0])
  );

  tta_pcu #(.WIDTH(W), .INIT(INITV), .NSTALL(NS), .RDEPTH(RD), .RDBITS(RB), .RELATIVE(1)) u_rel (
    .clock_i(clk), .reset_i(reset), .enable_i(enable), .pc_o(pc[1]), .fetch_o(fetch[1]),
    .latch_o(latch[1]), .ack_i(ack), .hit_i(hit), .target_i(tgt[1]), .branch_i(branch),
    .call_i(call), .ret_i(ret), .op_i(op), .busy_i(busy), .stall_no(stall_n[1]),
    .ras_empty_o(empty[1]), .ras_full_o(full[1]), .ras_err_o(err[1])
  );

  int checks = 0;
  int errors = 0;

  // Reference model: state as an int, stack as a queue (back = top of stack)
  int           m_st  [2];
  logic [W-1:0] m_pc  [2];
  logic [W-1:0] m_stk [2][$];
  logic         m_err [2];

  task automatic chkw(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%b expected=%b", name, $time, act, exp);
    end
  endtask

  task automatic model_step(int k, bit rel);
    logic [W-1:0] dest;
    bit           anyst;
    anyst = ((op & busy) != '0);
    if (reset) begin
      m_st[k]  = ST_FETCH;
      m_pc[k]  = INITV;
      m_err[k] = 1'b0;
      m_stk[k].delete();
      return;
    end
    dest = rel ? (m_pc[k] + tgt[k]) : tgt[k];
    if (ack && (m_st[k] == ST_FETCH || m_st[k] == ST_MISS)) begin
      if (ret) begin
        if (call) m_err[k] = 1'b1;
        if (m_stk[k].size() == 0) begin
          m_pc[k]++;
          m_err[k] = 1'b1;
        end else begin
          m_pc[k] = m_stk[k].pop_back();
        end
      end else if (call) begin
        m_stk[k].push_back(m_pc[k] + W'(1));
        if (m_stk[k].size() > RD) begin
          void'(m_stk[k].pop_front());
          m_err[k] = 1'b1;
        end
        m_pc[k] = dest;
      end else if (branch) begin
        m_pc[k] = dest;
      end else begin
        m_pc[k]++;
      end
    end
    case (m_st[k])
      ST_FETCH: m_st[k] = !enable ? ST_HALT : (!ack ? ST_MISS : (anyst ? ST_STALL : ST_FETCH));
      ST_MISS:  m_st[k] = (!anyst && hit) ? ST_FETCH : ST_MISS;
      ST_STALL: m_st[k] = anyst ? ST_STALL : (enable ? ST_FETCH : ST_HALT);
      default:  m_st[k] = enable ? ST_FETCH : ST_HALT;
    endcase
  endtask

  task automatic compare(int k);
    chkw($sformatf("pc%0d", k),     pc[k],      m_pc[k]);
    chk1($sformatf("stall_no%0d", k), stall_n[k], m_st[k] == ST_FETCH);
    chk1($sformatf("fetch%0d", k),  fetch[k],   m_st[k] == ST_FETCH || m_st[k] == ST_MISS);
    chk1($sformatf("latch%0d", k),  latch[k],   ack);
    chk1($sformatf("empty%0d", k),  empty[k],   m_stk[k].size() == 0);
    chk1($sformatf("full%0d", k),   full[k],    m_stk[k].size() == RD);
    chk1($sformatf("err%0d", k),    err[k],     m_err[k]);
  endtask

  // One clock: model advances on the edge, outputs are compared mid-cycle
  task automatic cyc();
    @(posedge clk);
    model_step(0, 1'b0);
    model_step(1, 1'b1);
    @(negedge clk);
    compare(0);
    compare(1);
  endtask

  task automatic idle();
    reset = 1'b0; enable = 1'b1; ack = 1'b0; hit = 1'b0;
    branch = 1'b0; call = 1'b0; ret = 1'b0;
    op = '0; busy = '0; tgt[0] = '0; tgt[1] = '0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    cyc();
    chkw("lit_reset_pc", pc[0], 12'h100);
    chk1("lit_reset_stall_no", stall_n[0], 1'b1);
    chk1("lit_reset_empty", empty[0], 1'b1);
    chk1("lit_reset_full", full[0], 1'b0);

    // sequential fetch
    idle(); ack = 1'b1;
    repeat (3) cyc();
    chkw("lit_seq_pc", pc[0], 12'h103);
    chk1("lit_seq_stall_no", stall_n[0], 1'b1);

    // miss, held by stall source 1, then refill
    idle();
    cyc();
    chk1("lit_miss_stall_no", stall_n[0], 1'b0);
    cyc();
    chk1("lit_miss_fetch", fetch[0], 1'b1);
    chkw("lit_miss_pc", pc[0], 12'h103);
    hit = 1'b1; op = 2'b10; busy = 2'b10;
    cyc();
    chk1("lit_miss_stalled", stall_n[0], 1'b0);
    op = '0; busy = '0;
    cyc();
    chk1("lit_miss_done", stall_n[0], 1'b1);

    // call / return, absolute and relative
    idle(); ack = 1'b1; branch = 1'b1; tgt[0] = 12'h010; tgt[1] = 12'hF0D;
    cyc();
    chkw("lit_br_abs", pc[0], 12'h010);
    chkw("lit_br_rel", pc[1], 12'h010);
    branch = 1'b0; call = 1'b1; tgt[0] = 12'h200; tgt[1] = 12'h0F0;
    cyc();
    chkw("lit_call_abs", pc[0], 12'h200);
    chkw("lit_call_rel", pc[1], 12'h100);
    call = 1'b0;
    cyc();
    chkw("lit_seq_after_call", pc[0], 12'h201);
    ret = 1'b1;
    cyc();
    chkw("lit_ret_abs", pc[0], 12'h011);
    chkw("lit_ret_rel", pc[1], 12'h011);
    chk1("lit_ret_empty", empty[0], 1'b1);

    // five nested calls overflow a four-deep stack
    ret = 1'b0; call = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tgt[0] = W'(12'h300 + 12'h010 * i);
      tgt[1] = tgt[0];
      cyc();
      if (i == 3) begin
        chk1("lit_ovf_full4", full[0], 1'b1);
        chk1("lit_ovf_err4", err[0], 1'b0);
      end
    end
    chk1("lit_ovf_err5", err[0], 1'b1);
    chkw("lit_ovf_pc", pc[0], 12'h340);
    call = 1'b0; ret = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chkw($sformatf("lit_lifo%0d", i), pc[0], W'(12'h331 - 12'h010 * i));
    end
    cyc();
    chkw("lit_underflow_pc", pc[0], 12'h302);
    chk1("lit_underflow_err", err[0], 1'b1);

    // halt, reset from halt, call+return conflict
    idle(); ack = 1'b1; enable = 1'b0;
    cyc();
    chk1("lit_halt_fetch", fetch[0], 1'b0);
    chkw("lit_halt_pc", pc[0], 12'h303);
    cyc();
    chkw("lit_halt_hold", pc[0], 12'h303);
    reset = 1'b1;
    cyc();
    chkw("lit_halt_reset_pc", pc[0], 12'h100);
    chk1("lit_halt_reset_err", err[0], 1'b0);
    chk1("lit_halt_reset_stall_no", stall_n[0], 1'b1);
    idle(); ack = 1'b1; call = 1'b1; tgt[0] = 12'h050; tgt[1] = 12'h050;
    cyc();
    ret = 1'b1; tgt[0] = 12'h400; tgt[1] = 12'h400;
    cyc();
    chkw("lit_conflict_pc", pc[0], 12'h101);
    chk1("lit_conflict_err", err[0], 1'b1);
    chk1("lit_conflict_empty", empty[0], 1'b1);

    // wrap and stall
    idle(); ack = 1'b1; branch = 1'b1; tgt[0] = 12'hFFF; tgt[1] = 12'hEFE;
    cyc();
    chkw("lit_wrap_pre", pc[0], 12'hFFF);
    chkw("lit_wrap_pre_rel", pc[1], 12'hFFF);
    branch = 1'b0;
    cyc();
    chkw("lit_wrap_pc", pc[0], 12'h000);
    chkw("lit_wrap_pc_rel", pc[1], 12'h000);
    op = 2'b01; busy = 2'b01;
    cyc();
    chk1("lit_stall_stall_no", stall_n[0], 1'b0);
    chkw("lit_stall_pc", pc[0], 12'h001);
    cyc();
    chkw("lit_stall_hold", pc[0], 12'h001);
    busy = 2'b00; ack = 1'b0;
    cyc();
    chk1("lit_stall_release", stall_n[0], 1'b1);
    chkw("lit_stall_release_pc", pc[0], 12'h001);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      reset  = ($urandom_range(0, 199) == 0);
      enable = ($urandom_range(0, 9) != 0);
      ack    = ($urandom_range(0, 9) < 7);
      hit    = $urandom_range(0, 1) != 0;
      branch = ($urandom_range(0, 7) == 0);
      call   = ($urandom_range(0, 7) == 0);
      ret    = ($urandom_range(0, 7) == 0);
      op     = NS'($urandom_range(0, 3));
      busy   = NS'($urandom_range(0, 3)) & NS'($urandom_range(0, 3));
      tgt[0] = W'($urandom());
      tgt[1] = W'($urandom());
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
